// File: rtl/bitwise_alu_pipe.sv
// bitwise_alu_pipe: two-stage valid/ready pipelined bitwise and bit-field unit
module bitwise_alu_pipe #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_In_Valid,
    output logic             o_In_Ready,
    input  logic [3:0]       i_Op,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_Out_Valid,
    input  logic             i_Out_Ready,
    output logic [WIDTH-1:0] o_Result,
    output logic             o_Err,
    output logic [CNTW-1:0]  o_Op_Count
);
    localparam int IDXW = $clog2(WIDTH);

    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             s1_load, s2_load, xfer;
    logic [IDXW-1:0]  lsb;
    logic [IDXW:0]    len;
    logic [WIDTH-1:0] field, pop, alu;

    always_comb begin
        lsb   = s1_b_q[IDXW-1:0];
        len   = {1'b0, s1_b_q[2*IDXW-1:IDXW]} + (IDXW+1)'(1);
        // a length of WIDTH shifts every ones bit out, leaving a full mask
        field = (s1_a_q >> lsb) & ~({WIDTH{1'b1}} << len);
        pop   = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + WIDTH'(s1_a_q[i]);
        alu   = '0;
        case (s1_op_q)
            4'd0:  alu = s1_a_q & s1_b_q;
            4'd1:  alu = s1_a_q | s1_b_q;
            4'd2:  alu = s1_a_q ^ s1_b_q;
            4'd3:  alu = ~s1_a_q;
            4'd4:  alu = ~(s1_a_q & s1_b_q);
            4'd5:  alu = ~(s1_a_q | s1_b_q);
            4'd6:  alu = ~(s1_a_q ^ s1_b_q);
            4'd7:  alu = field;
            4'd8:  alu = WIDTH'(&s1_a_q);
            4'd9:  alu = WIDTH'(|s1_a_q);
            4'd10: alu = WIDTH'(^s1_a_q);
            4'd11: alu = pop;
            default: alu = '0;
        endcase
    end

    always_comb begin
        s2_load     = !out_valid_q | i_Out_Ready;
        s1_load     = !s1_valid_q | s2_load;
        xfer        = out_valid_q & i_Out_Ready;
        s1_valid_d  = s1_load ? i_In_Valid : s1_valid_q;
        s1_op_d     = s1_load ? i_Op : s1_op_q;
        s1_a_d      = s1_load ? i_A : s1_a_q;
        s1_b_d      = s1_load ? i_B : s1_b_q;
        out_valid_d = s2_load ? s1_valid_q : out_valid_q;
        result_d    = (s2_load & s1_valid_q) ? alu : result_q;
        err_d       = (s2_load & s1_valid_q) ? (s1_op_q[3] & s1_op_q[2]) : err_q;
        cnt_d       = (xfer && cnt_q != '1) ? cnt_q + CNTW'(1) : cnt_q;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_In_Ready  = s1_load;
    assign o_Out_Valid = out_valid_q;
    assign o_Result    = result_q;
    assign o_Err       = err_q;
    assign o_Op_Count  = cnt_q;
endmodule
